modbus_rtu_frame_tx: RTL and testbench

Parametrised Modbus RTU frame transmitter. Software or an upstream FSM fills a byte buffer of up to MAX_BYTES bytes, then issues start. The block streams the buffer through the existing uart_byte_tx handshake, optionally appends CRC-16/Modbus (low byte first) and drives rs485_oe. It then enforces a configurable inter-frame silence before it reports done. It replaces fixed-length 8-byte frame generation and serves as the master-side / bench-side companion to modbus_rtu_slave_top.

---
 rtl/modbus_rtu_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_modbus_rtu_frame_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_frame_tx.sv
// rtl/modbus_rtu_frame_tx.sv - Modbus RTU frame transmitter: byte buffer, CRC-16 append, RS-485 enable, inter-frame gap
module modbus_rtu_frame_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int MAX_BYTES  = 32,
    parameter bit CRC_APPEND = 1'b1,
    parameter int GAP_BITS   = 35,
    localparam int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_clr,
    input  logic          start,
    output logic [CW-1:0] byte_cnt,
    output logic          full,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   crc_out,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_done,
    output logic          rs485_oe
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int GAP_CYCLES = BIT_CYCLES * GAP_BITS;
    localparam int GW         = $clog2(GAP_CYCLES + 1);
    localparam int AW         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [1:0] PH_DATA = 2'd0;
    localparam logic [1:0] PH_CRCL = 2'd1;
    localparam logic [1:0] PH_CRCH = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CRC_L,
        CRC_H,
        GAP
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [7:0]     buf_mem [MAX_BYTES];
    logic [CW-1:0]  idx;
    logic [CW-1:0]  idx_nxt;
    logic [15:0]    crc;
    logic [GW-1:0]  gap_cnt;
    // WAIT is shared by data and CRC bytes; phase tells which byte it is waiting on
    logic [1:0]     phase;

    logic           start_ok;
    logic           wr_ok;
    logic           clr_ok;
    logic           last_byte;
    logic           gap_last;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign busy      = (state != IDLE);
    assign full      = (byte_cnt == CW'(MAX_BYTES));
    assign tx_start  = (state == ISSUE) || (state == CRC_L) || (state == CRC_H);
    assign rs485_oe  = tx_start || (state == WAIT);

    assign start_ok  = start && (state == IDLE) && (byte_cnt != '0);
    assign clr_ok    = wr_clr && !busy;
    assign wr_ok     = wr_en && !wr_clr && !busy && !full;
    assign idx_nxt   = idx + CW'(1);
    assign last_byte = (idx_nxt >= byte_cnt);
    assign gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = ISSUE;
            end
            ISSUE, CRC_L, CRC_H: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (phase == PH_CRCH)      state_nxt = GAP;
                    else if (phase == PH_CRCL) state_nxt = CRC_H;
                    else if (!last_byte)       state_nxt = ISSUE;
                    else if (CRC_APPEND)       state_nxt = CRC_L;
                    else                       state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer storage carries no reset; byte_cnt alone defines what is valid
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            buf_mem[byte_cnt[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            idx      <= '0;
            crc      <= 16'hFFFF;
            crc_out  <= 16'hFFFF;
            tx_data  <= 8'h00;
            phase    <= PH_DATA;
            gap_cnt  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= start && !start_ok;

            if (clr_ok) begin
                byte_cnt <= '0;
            end else if (wr_ok) begin
                byte_cnt <= byte_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        idx     <= '0;
                        crc     <= 16'hFFFF;
                        phase   <= PH_DATA;
                        tx_data <= buf_mem[0];
                    end
                end
                ISSUE: begin
                    crc <= crc16_byte(crc, tx_data);
                end
                WAIT: begin
                    if (tx_done) begin
                        gap_cnt <= '0;
                        case (state_nxt)
                            ISSUE: begin
                                idx     <= idx_nxt;
                                tx_data <= buf_mem[idx_nxt[AW-1:0]];
                            end
                            CRC_L: begin
                                phase   <= PH_CRCL;
                                tx_data <= crc[7:0];
                            end
                            CRC_H: begin
                                phase   <= PH_CRCH;
                                tx_data <= crc[15:8];
                            end
                            default: ;
                        endcase
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_last) begin
                        done    <= 1'b1;
                        crc_out <= crc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_rtu_frame_tx.sv
// tb/tb_modbus_rtu_frame_tx.sv - scoreboard bench for modbus_rtu_frame_tx (CRC and no-CRC instances)
module tb_modbus_rtu_frame_tx;

    localparam int CW    = 6;
    localparam int GAP_A = 15190;

    logic          clk;
    logic          rst_n;
    int            n_pass;
    int            n_total;
    int            cyc;

    logic          wr_en_a, wr_clr_a, start_a, tx_done_a, resp_done_a, stray_done;
    logic [7:0]    wr_data_a, tx_data_a;
    logic [CW-1:0] byte_cnt_a;
    logic          full_a, busy_a, done_a, err_a, tx_start_a, rs485_oe_a;
    logic [15:0]   crc_out_a;

    logic          wr_en_b, wr_clr_b, start_b, tx_done_b;
    logic [7:0]    wr_data_b, tx_data_b;
    logic [CW-1:0] byte_cnt_b;
    logic          full_b, busy_b, done_b, err_b, tx_start_b, rs485_oe_b;
    logic [15:0]   crc_out_b;

    logic [7:0]    exp_a [$];
    logic [15:0]   exp_crc_a [$];
    logic [7:0]    exp_b [$];
    logic [15:0]   exp_crc_b [$];
    logic [7:0]    frm [$];

    int            starts_a, starts_b, done_cnt_a, done_cnt_b;
    int            fall_cyc_a, done_cyc_a;
    logic          oe_prev_a;

    assign tx_done_a = resp_done_a | stray_done;

    modbus_rtu_frame_tx dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_a),
        .wr_data  (wr_data_a),
        .wr_clr   (wr_clr_a),
        .start    (start_a),
        .byte_cnt (byte_cnt_a),
        .full     (full_a),
        .busy     (busy_a),
        .done     (done_a),
        .err      (err_a),
        .crc_out  (crc_out_a),
        .tx_start (tx_start_a),
        .tx_data  (tx_data_a),
        .tx_done  (tx_done_a),
        .rs485_oe (rs485_oe_a)
    );

    modbus_rtu_frame_tx #(
        .CLK_FREQ   (1000000),
        .BAUD_RATE  (100000),
        .MAX_BYTES  (32),
        .CRC_APPEND (1'b0),
        .GAP_BITS   (35)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_b),
        .wr_data  (wr_data_b),
        .wr_clr   (wr_clr_b),
        .start    (start_b),
        .byte_cnt (byte_cnt_b),
        .full     (full_b),
        .busy     (busy_b),
        .done     (done_b),
        .err      (err_b),
        .crc_out  (crc_out_b),
        .tx_start (tx_start_b),
        .tx_data  (tx_data_b),
        .tx_done  (tx_done_b),
        .rs485_oe (rs485_oe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] q [$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    // Byte-level UART stand-ins: acknowledge each tx_start a few cycles later
    initial begin
        logic [7:0] held;
        resp_done_a = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_a) begin
                held = tx_data_a;
                repeat (3) @(posedge clk);
                #1;
                if (rs485_oe_a) check("tx_data_a hold", tx_data_a, held);
                resp_done_a = 1'b1;
                @(posedge clk);
                #1 resp_done_a = 1'b0;
            end
        end
    end

    initial begin
        tx_done_b = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_b) begin
                repeat (2) @(posedge clk);
                #1 tx_done_b = 1'b1;
                @(posedge clk);
                #1 tx_done_b = 1'b0;
            end
        end
    end

    initial begin
        starts_a = 0; starts_b = 0; done_cnt_a = 0; done_cnt_b = 0;
        fall_cyc_a = 0; done_cyc_a = 0; oe_prev_a = 1'b0;
    end

    always @(negedge clk) begin
        if (oe_prev_a && !rs485_oe_a) fall_cyc_a = cyc;
        oe_prev_a = rs485_oe_a;
        if (tx_start_a) begin
            starts_a++;
            if (exp_a.size() == 0) begin
                n_total++;
                $display("FAIL tx_byte_a: unexpected tx_start, data %0h", tx_data_a);
            end else begin
                check("tx_byte_a", tx_data_a, exp_a.pop_front());
            end
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
            check("busy_a at done", busy_a, 0);
            if (exp_crc_a.size() == 0) begin
                n_total++;
                $display("FAIL crc_out_a: unexpected done, crc %0h", crc_out_a);
            end else begin
                check("crc_out_a", crc_out_a, exp_crc_a.pop_front());
            end
        end
        if (tx_start_b) begin
            starts_b++;
            if (exp_b.size() == 0) begin
                n_total++;
                $display("FAIL tx_byte_b: unexpected tx_start, data %0h", tx_data_b);
            end else begin
                check("tx_byte_b", tx_data_b, exp_b.pop_front());
            end
        end
        if (done_b) begin
            done_cnt_b++;
            if (exp_crc_b.size() == 0) begin
                n_total++;
                $display("FAIL crc_out_b: unexpected done, crc %0h", crc_out_b);
            end else begin
                check("crc_out_b", crc_out_b, exp_crc_b.pop_front());
            end
        end
    end

    task automatic write_a(input logic [7:0] d);
        wr_en_a = 1'b1; wr_data_a = d;
        tick();
        wr_en_a = 1'b0;
    endtask

    task automatic load_frame_a();
        wr_clr_a = 1'b1;
        tick();
        wr_clr_a = 1'b0;
        foreach (frm[i]) write_a(frm[i]);
    endtask

    task automatic wait_done_a(input int prev);
        int t;
        t = 0;
        while (done_cnt_a == prev && t < 20000) begin
            tick();
            t++;
        end
        if (done_cnt_a == prev) begin
            n_total++;
            $display("FAIL done_a timeout: no done after %0d cycles", t);
        end
    endtask

    task automatic send_frame_a(input string tag, input logic [15:0] crc, input bit probe);
        int s0, d0, t;
        foreach (frm[i]) exp_a.push_back(frm[i]);
        exp_a.push_back(crc[7:0]);
        exp_a.push_back(crc[15:8]);
        exp_crc_a.push_back(crc);
        s0 = starts_a;
        d0 = done_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, " first tx_start latency"}, tx_start_a, 1);
        check({tag, " busy/oe after start"}, {busy_a, rs485_oe_a}, 2'b11);
        if (probe) begin
            tick();
            write_a(8'h55);
            check({tag, " wr_en while busy"}, byte_cnt_a, 32'(frm.size()));
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            check({tag, " err on start in WAIT"}, err_a, 1);
            tick();
            check({tag, " err one cycle"}, err_a, 0);
            t = 0;
            while (rs485_oe_a && t < 5000) begin
                tick();
                t++;
            end
            check({tag, " oe low in GAP"}, rs485_oe_a, 0);
            check({tag, " busy in GAP"}, busy_a, 1);
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            check({tag, " err on start in GAP"}, err_a, 1);
        end
        wait_done_a(d0);
        check({tag, " done one cycle"}, done_a, 0);
        check({tag, " gap cycles"}, done_cyc_a - fall_cyc_a, GAP_A);
        check({tag, " tx_start count"}, starts_a - s0, 32'(frm.size() + 2));
        check({tag, " bytes drained"}, exp_a.size(), 0);
    endtask

    initial begin
        int s0, t;
        logic [15:0] c;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; stray_done = 1'b0;
        wr_en_a = 0; wr_clr_a = 0; start_a = 0; wr_data_a = 8'h00;
        wr_en_b = 0; wr_clr_b = 0; start_b = 0; wr_data_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset byte_cnt", byte_cnt_a, 0);
        check("reset full", full_a, 0);
        check("reset busy/done/err", {busy_a, done_a, err_a}, 3'b000);
        check("reset tx_start/oe", {tx_start_a, rs485_oe_a}, 2'b00);
        check("reset tx_data", tx_data_a, 8'h00);
        check("reset crc_out", crc_out_a, 16'hFFFF);
        rst_n = 1'b1;
        tick();

        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("empty start err", err_a, 1);
        check("empty start busy", busy_a, 0);
        check("empty start no tx", tx_start_a, 0);
        tick();
        check("empty err one cycle", err_a, 0);

        frm = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01};
        load_frame_a();
        check("frame1 byte_cnt", byte_cnt_a, 6);
        send_frame_a("frame1", 16'hCAD5, 1'b1);

        frm = '{8'hF0, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01};
        load_frame_a();
        send_frame_a("frame2", 16'hEBC0, 1'b0);
        check("frame2 buffer retained", byte_cnt_a, 6);
        send_frame_a("frame2 repeat", 16'hEBC0, 1'b0);

        wr_clr_b = 1'b1;
        tick();
        wr_clr_b = 1'b0;
        frm = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h07};
        foreach (frm[i]) begin
            wr_en_b = 1'b1; wr_data_b = frm[i];
            tick();
            wr_en_b = 1'b0;
            exp_b.push_back(frm[i]);
        end
        check("nocrc byte_cnt", byte_cnt_b, 6);
        exp_crc_b.push_back(16'hC899);
        s0 = starts_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        t = 0;
        while (done_cnt_b == 0 && t < 2000) begin
            tick();
            t++;
        end
        check("nocrc done seen", done_cnt_b, 1);
        check("nocrc tx_start count", starts_b - s0, 6);
        check("nocrc bytes drained", exp_b.size(), 0);

        frm.delete();
        for (int i = 0; i < 32; i++) frm.push_back(8'((i * 37 + 5) & 8'hFF));
        load_frame_a();
        check("max full before extra", full_a, 1);
        write_a(8'hEE);
        check("max byte_cnt saturates", byte_cnt_a, 32);
        check("max full", full_a, 1);
        c = crc_model(frm);
        send_frame_a("max frame", c, 1'b0);

        frm = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load_frame_a();
        foreach (frm[i]) exp_a.push_back(frm[i]);
        s0 = starts_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        t = 0;
        while (starts_a < s0 + 3 && t < 200) begin
            tick();
            t++;
        end
        check("reset test reached byte 3", starts_a - s0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midframe reset busy/done/err", {busy_a, done_a, err_a}, 3'b000);
        check("midframe reset tx_start/oe", {tx_start_a, rs485_oe_a}, 2'b00);
        check("midframe reset tx_data", tx_data_a, 8'h00);
        check("midframe reset byte_cnt", byte_cnt_a, 0);
        check("midframe reset crc_out", crc_out_a, 16'hFFFF);
        exp_a.delete();
        s0 = starts_a;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (10) tick();
        check("stray tx_done no tx_start", starts_a - s0, 0);
        check("after reset byte_cnt", byte_cnt_a, 0);
        check("after reset busy", busy_a, 0);
        check("no spurious done", exp_crc_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
